// File: rtl/bp_me_mem_cmd_responder_pkg.sv
// Shared message types, geometry and byte-mask helper for the
// memory-side engine blocks on the cce_mem_msg link.
package bp_me_mem_cmd_responder_pkg;

    localparam int paddr_width_gp     = 40;
    localparam int cce_block_width_gp = 512;
    localparam int lce_id_width_gp    = 4;
    localparam int uce_assoc_gp       = 4;
    localparam int way_id_width_gp    = $clog2(uce_assoc_gp);
    localparam int block_bytes_gp     = cce_block_width_gp / 8;
    localparam int block_off_gp       = $clog2(block_bytes_gp);
    localparam int mem_els_gp         = 1024;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3,
        e_cce_mem_wb    = 4'd4
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'd0,
        e_mem_msg_size_2  = 3'd1,
        e_mem_msg_size_4  = 3'd2,
        e_mem_msg_size_8  = 3'd3,
        e_mem_msg_size_16 = 3'd4,
        e_mem_msg_size_32 = 3'd5,
        e_mem_msg_size_64 = 3'd6
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] lce_id;
        logic [way_id_width_gp-1:0] way_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_cmd_type_e          msg_type;
        logic [paddr_width_gp-1:0]     addr;
        bp_mem_msg_size_e              size;
        bp_cce_mem_payload_s           payload;
        logic [cce_block_width_gp-1:0] data;
    } bp_cce_mem_msg_s;

    // Bit mask covering the low 2^size bytes of a block.
    function automatic logic [cce_block_width_gp-1:0] size_to_mask(
        input logic [2:0] size
    );
        logic [cce_block_width_gp-1:0] m;
        m = '0;
        for (int i = 0; i < block_bytes_gp; i++) begin
            if (i < (1 << size)) m[i*8 +: 8] = 8'hff;
        end
        return m;
    endfunction

endpackage

// File: rtl/bp_me_mem_cmd_responder_merge.sv
// Byte extract / read-modify-write merge of a sub-block access
// at a byte offset inside one cache block.
module bp_me_mem_cmd_responder_merge
    import bp_me_mem_cmd_responder_pkg::*;
(
    input  logic [cce_block_width_gp-1:0] blk_i,
    input  logic [block_off_gp-1:0]       off_i,
    input  logic [2:0]                    size_i,
    input  logic [cce_block_width_gp-1:0] wdata_i,
    output logic [cce_block_width_gp-1:0] merged_o,
    output logic [cce_block_width_gp-1:0] extract_o,
    output logic                          overflow_o
);

    logic [block_off_gp+2:0]       shamt;
    logic [cce_block_width_gp-1:0] mask;

    always_comb begin
        shamt     = {off_i, 3'b000};
        mask      = size_to_mask(size_i);
        extract_o = (blk_i >> shamt) & mask;
        // Bytes shifted past the block top simply fall off.
        merged_o  = (blk_i & ~(mask << shamt))
                  | ((wdata_i & mask) << shamt);
        overflow_o = (32'(off_i) + (32'd1 << size_i))
                   > 32'(block_bytes_gp);
    end

endmodule

// File: rtl/bp_me_mem_cmd_responder.sv
// Single-outstanding memory-side responder: services cce_mem_msg
// commands against a block-wide synchronous SRAM.
module bp_me_mem_cmd_responder
    import bp_me_mem_cmd_responder_pkg::*;
#(
    parameter int mem_els_p = mem_els_gp,
    parameter int latency_p = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  bp_cce_mem_msg_s mem_cmd_i,
    input  logic            mem_cmd_v_i,
    output logic            mem_cmd_ready_o,
    output bp_cce_mem_msg_s mem_resp_o,
    output logic            mem_resp_v_o,
    input  logic            mem_resp_yumi_i
);

    localparam int idx_width_lp =
        (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam logic [7:0] lat_load_lp =
        (latency_p > 0) ? 8'(latency_p - 1) : 8'd0;

    typedef enum logic [2:0] {
        e_ready,
        e_access,
        e_delay,
        e_write,
        e_resp
    } state_e;

    state_e                        state_q, state_d;
    bp_cce_mem_msg_s               cmd_q, cmd_d;
    bp_cce_mem_msg_s               resp_q, resp_d;
    logic [cce_block_width_gp-1:0] blk_q, blk_d;
    logic [7:0]                    cnt_q, cnt_d;

    logic [cce_block_width_gp-1:0] mem_q [mem_els_p];
    logic [cce_block_width_gp-1:0] rdata_q;
    logic [idx_width_lp-1:0]       mem_idx;
    logic                          mem_we;
    logic [cce_block_width_gp-1:0] mem_wdata;

    logic [cce_block_width_gp-1:0] merged;
    logic [cce_block_width_gp-1:0] extract;
    logic                          uc_overflow;

    bp_me_mem_cmd_responder_merge u_merge (
        .blk_i      (blk_q),
        .off_i      (cmd_q.addr[block_off_gp-1:0]),
        .size_i     (cmd_q.size),
        .wdata_i    (cmd_q.data),
        .merged_o   (merged),
        .extract_o  (extract),
        .overflow_o (uc_overflow)
    );

    // Single-port storage: a write cycle suppresses the read.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
        else        rdata_q        <= mem_q[mem_idx];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cmd_q <= cmd_d;
        blk_q <= blk_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        blk_d     = blk_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        mem_we    = 1'b0;
        mem_idx   = cmd_q.addr[block_off_gp +: idx_width_lp];
        mem_wdata = merged;
        unique case (state_q)
            e_ready: begin
                mem_idx = mem_cmd_i.addr[block_off_gp +: idx_width_lp];
                if (mem_cmd_v_i) begin
                    cmd_d   = mem_cmd_i;
                    state_d = e_access;
                end
            end
            e_access: begin
                blk_d   = rdata_q;
                cnt_d   = lat_load_lp;
                state_d = (latency_p == 0) ? e_write : e_delay;
            end
            e_delay: begin
                if (cnt_q == 8'd0) state_d = e_write;
                else               cnt_d   = cnt_q - 8'd1;
            end
            e_write: begin
                resp_d      = cmd_q;
                resp_d.data = '0;
                // Writes are gated so a reset here leaves memory intact.
                unique case (cmd_q.msg_type)
                    e_cce_mem_rd,
                    e_cce_mem_wr:    resp_d.data = blk_q;
                    e_cce_mem_uc_rd: resp_d.data = extract;
                    e_cce_mem_wb: begin
                        mem_we    = !reset_i;
                        mem_wdata = cmd_q.data;
                    end
                    e_cce_mem_uc_wr: mem_we = !reset_i;
                    default: ;
                endcase
                state_d = e_resp;
            end
            e_resp: begin
                if (mem_resp_yumi_i) state_d = e_ready;
            end
            default: state_d = e_ready;
        endcase
    end

    assign mem_cmd_ready_o = (state_q == e_ready) && !reset_i;
    assign mem_resp_v_o    = (state_q == e_resp) && !reset_i;
    assign mem_resp_o      = reset_i ? '0 : resp_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == e_write) begin
            a_known_type: assert (cmd_q.msg_type inside {
                e_cce_mem_rd, e_cce_mem_wr, e_cce_mem_wb,
                e_cce_mem_uc_rd, e_cce_mem_uc_wr});
            if (cmd_q.msg_type inside {e_cce_mem_uc_rd, e_cce_mem_uc_wr})
                a_uc_in_block: assert (!uc_overflow);
        end
        if (!reset_i)
            a_yumi_legal: assert (!mem_resp_yumi_i || mem_resp_v_o);
    end

endmodule

// File: tb/tb_bp_me_mem_cmd_responder.sv
// Randomized self-checking bench: three responders with different
// latencies checked against a byte-level memory model.
module tb_bp_me_mem_cmd_responder;
    import bp_me_mem_cmd_responder_pkg::*;

    localparam int N       = 3;
    localparam int MEM_ELS = 1024;
    localparam int BB      = 64;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 0 : 7);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset  [N];
    bp_cce_mem_msg_s cmd    [N];
    logic            cmd_v  [N];
    logic            ready  [N];
    bp_cce_mem_msg_s resp   [N];
    logic            resp_v [N];
    logic            yumi   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        bp_me_mem_cmd_responder #(
            .mem_els_p (MEM_ELS),
            .latency_p (lat_of(g))
        ) dut (
            .clk_i           (clk),
            .reset_i         (reset[g]),
            .mem_cmd_i       (cmd[g]),
            .mem_cmd_v_i     (cmd_v[g]),
            .mem_cmd_ready_o (ready[g]),
            .mem_resp_o      (resp[g]),
            .mem_resp_v_o    (resp_v[g]),
            .mem_resp_yumi_i (yumi[g])
        );
    end

    int checks = 0;
    int errors = 0;

    logic [511:0] mdl [N][MEM_ELS];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic bp_cce_mem_msg_s mk(
        input bp_cce_mem_cmd_type_e t,
        input logic [39:0] a,
        input int sz,
        input logic [511:0] d
    );
        bp_cce_mem_msg_s c;
        c.msg_type       = t;
        c.addr           = a;
        c.size           = bp_mem_msg_size_e'(3'(sz));
        c.payload.lce_id = 4'($urandom);
        c.payload.way_id = 2'($urandom);
        c.data           = d;
        return c;
    endfunction

    // Memory seen as an array of byte-addressed blocks.
    function automatic logic [511:0] model_exec(
        input int k,
        input bp_cce_mem_msg_s c
    );
        int idx, off, n;
        logic [511:0] blk, r;
        idx = int'((c.addr / BB) % MEM_ELS);
        off = int'(c.addr % BB);
        n   = 1 << int'(c.size);
        blk = mdl[k][idx];
        r   = '0;
        case (c.msg_type)
            e_cce_mem_rd, e_cce_mem_wr: r = blk;
            e_cce_mem_wb: mdl[k][idx] = c.data;
            e_cce_mem_uc_rd:
                for (int i = 0; i < n; i++)
                    r[i*8 +: 8] = blk[(off+i)*8 +: 8];
            e_cce_mem_uc_wr: begin
                for (int i = 0; i < n; i++)
                    blk[(off+i)*8 +: 8] = c.data[i*8 +: 8];
                mdl[k][idx] = blk;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic send(
        input int k,
        input bp_cce_mem_msg_s c,
        input int hold,
        output bp_cce_mem_msg_s got
    );
        bp_cce_mem_msg_s exp, snap;
        int t;
        bit bad;
        exp      = c;
        exp.data = model_exec(k, c);
        got      = '0;
        cmd[k]   = c;
        cmd_v[k] = 1'b1;
        t = 0;
        while (ready[k] !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL accept dut%0d: ready=%b required 1", k, ready[k]);
            cmd_v[k] = 1'b0;
            return;
        end
        step();
        cmd_v[k]       = 1'b0;
        cmd[k].addr    = {8'($urandom), $urandom};
        cmd[k].data    = rand_block();
        t   = 1;
        bad = 1'b0;
        while (resp_v[k] !== 1'b1 && t < 400) begin
            if (ready[k] !== 1'b0) bad = 1'b1;
            step();
            t++;
        end
        checks++;
        if (t != 3 + lat_of(k)) begin
            errors++;
            $display("FAIL latency dut%0d: cycles=%0d required %0d",
                     k, t, 3 + lat_of(k));
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL busy_ready dut%0d: ready=1 required 0", k);
        end
        if (resp_v[k] !== 1'b1) return;
        got = resp[k];
        checks++;
        if (resp[k] !== exp) begin
            errors++;
            $display("FAIL resp dut%0d: got=%h required=%h",
                     k, resp[k], exp);
        end
        snap = resp[k];
        bad  = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            if (resp_v[k] !== 1'b1 || resp[k] !== snap || ready[k] !== 1'b0)
                bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL stall dut%0d: v=%b ready=%b required v=1 ready=0 stable",
                         k, resp_v[k], ready[k]);
            end
        end
        yumi[k] = 1'b1;
        step();
        yumi[k] = 1'b0;
        checks++;
        if (ready[k] !== 1'b1 || resp_v[k] !== 1'b0) begin
            errors++;
            $display("FAIL post_yumi dut%0d: ready=%b v=%b required 1/0",
                     k, ready[k], resp_v[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            reset[k] = 1'b1;
            cmd_v[k] = 1'b0;
            yumi[k]  = 1'b0;
            cmd[k]   = '0;
        end
        step();
        step();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ready[k] !== 1'b0 || resp_v[k] !== 1'b0 || resp[k] !== '0) begin
                errors++;
                $display("FAIL reset_out dut%0d: ready=%b v=%b required 0/0, resp zero",
                         k, ready[k], resp_v[k]);
            end
            reset[k] = 1'b0;
        end
        step();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ready[k] !== 1'b1 || resp_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_exit dut%0d: ready=%b v=%b required 1/0",
                         k, ready[k], resp_v[k]);
            end
        end
    endtask

    task automatic test_wb_rd();
        bp_cce_mem_msg_s got;
        logic [511:0] a;
        a = rand_block();
        send(0, mk(e_cce_mem_wb, 40'h00_8000_0040, 6, a), 0, got);
        send(0, mk(e_cce_mem_rd, 40'h00_8000_0040, 6, rand_block()), 0, got);
        checks++;
        if (got.data !== a) begin
            errors++;
            $display("FAIL wb_rd_data: got=%h required=%h", got.data, a);
        end
    endtask

    task automatic test_uc();
        bp_cce_mem_msg_s got;
        logic [511:0] d;
        d = 512'hDEADBEEF;
        send(0, mk(e_cce_mem_wb, 40'h00_8000_0080, 6, '0), 0, got);
        send(0, mk(e_cce_mem_uc_wr, 40'h00_8000_0084, 2, d), 0, got);
        send(0, mk(e_cce_mem_uc_rd, 40'h00_8000_0080, 3, '0), 0, got);
        checks++;
        if (got.data !== 512'hDEADBEEF_00000000) begin
            errors++;
            $display("FAIL uc_rd8: got=%h required deadbeef00000000", got.data[63:0]);
        end
        send(0, mk(e_cce_mem_uc_rd, 40'h00_8000_0087, 0, '0), 0, got);
        checks++;
        if (got.data !== 512'hDE) begin
            errors++;
            $display("FAIL uc_rd1: got=%h required de", got.data[63:0]);
        end
    endtask

    task automatic test_stall();
        bp_cce_mem_msg_s got;
        send(0, mk(e_cce_mem_rd, 40'h00_8000_0040, 6, '0), 20, got);
    endtask

    task automatic test_back_to_back();
        bp_cce_mem_msg_s got;
        bp_cce_mem_cmd_type_e t;
        int sz, off, b;
        logic [39:0] a;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 8; i++) begin
                a = (40'($urandom) << 16) | 40'(i * BB);
                send(k, mk(e_cce_mem_wb, a, 6, rand_block()), 0, got);
            end
            for (int i = 0; i < 40; i++) begin
                t  = bp_cce_mem_cmd_type_e'(4'($urandom_range(0, 4)));
                b  = $urandom_range(0, 7);
                sz = 6;
                if (t == e_cce_mem_uc_rd || t == e_cce_mem_uc_wr)
                    sz = $urandom_range(0, 6);
                off = $urandom_range(0, BB - (1 << sz));
                a   = (40'($urandom) << 16) | 40'(b * BB + off);
                send(k, mk(t, a, sz, rand_block()), 0, got);
            end
        end
    endtask

    task automatic test_reset_mid();
        bp_cce_mem_msg_s got;
        logic [511:0] a;
        logic [39:0] addr;
        bit bad;
        int when [2];
        when[0] = 3;
        when[1] = 2 + lat_of(0);
        addr = 40'h00_0000_0500;
        for (int w = 0; w < 2; w++) begin
            a = rand_block();
            send(0, mk(e_cce_mem_wb, addr, 6, a), 0, got);
            cmd[0]   = mk(e_cce_mem_wb, addr, 6, rand_block());
            cmd_v[0] = 1'b1;
            step();
            cmd_v[0] = 1'b0;
            for (int c = 1; c < when[w]; c++) step();
            reset[0] = 1'b1;
            #1;
            checks++;
            if (ready[0] !== 1'b0 || resp_v[0] !== 1'b0 || resp[0] !== '0) begin
                errors++;
                $display("FAIL mid_reset_out at %0d: ready=%b v=%b required 0/0",
                         when[w], ready[0], resp_v[0]);
            end
            step();
            reset[0] = 1'b0;
            #1;
            checks++;
            if (ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_ready at %0d: ready=%b required 1",
                         when[w], ready[0]);
            end
            bad = 1'b0;
            for (int c = 0; c < 12; c++) begin
                if (resp_v[0] !== 1'b0) bad = 1'b1;
                step();
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL mid_reset_resp at %0d: v=1 required 0", when[w]);
            end
            send(0, mk(e_cce_mem_rd, addr, 6, '0), 0, got);
            checks++;
            if (got.data !== a) begin
                errors++;
                $display("FAIL mid_reset_mem at %0d: got=%h required=%h",
                         when[w], got.data[127:0], a[127:0]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            reset[k] = 1'b1;
            cmd_v[k] = 1'b0;
            yumi[k]  = 1'b0;
            cmd[k]   = '0;
        end
        step();
        test_reset();
        test_wb_rd();
        test_uc();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/bp_me_mem_cmd_responder.md
Name: bp_me_mem_cmd_responder

Overview:
- Single-outstanding memory-side responder for the cce_mem_msg protocol. It is the far end of a UCE/CCE mem_cmd/mem_resp link.
- Accepts mem_cmd messages and services them against a block-wide synchronous SRAM. Returns one mem_resp per command after a programmable extra latency.
- Used as the backing memory in tile-level testbenches and small FPGA configs.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p.
- uce_assoc_p, 4, way_id width passed in payload; echoed in the response, not interpreted.
- mem_els_p, 1024, number of cce_block_width_p-bit blocks stored.
- latency_p, 4, extra cycles of delay between the SRAM access and response valid. Legal range 0..255.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- mem_cmd_i  in  cce_mem_msg_width_lp  command message (msg_type, addr, size, payload, data).
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  ready; a command is accepted when v & ready.
- mem_resp_o  out  cce_mem_msg_width_lp  response message.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  consumer takes the response; only legal when mem_resp_v_o=1.

Behaviour:
- Interface: one clock (clk_i); reset_i is synchronous and active-high.
- Reset: state=e_ready next cycle. During reset: mem_cmd_ready_o=0, mem_resp_v_o=0, mem_resp_o='0. SRAM contents are not cleared (undefined).
- Reset mid-operation: the pending command is dropped, no response is issued, and no SRAM write occurs on the reset cycle.
- Block index = addr[block_off +: clog2(mem_els_p)], with block_off = clog2(cce_block_width_p/8). Higher address bits are ignored (aliasing).
- Command handling by msg_type:
  - e_cce_mem_rd and e_cce_mem_wr (read-for-write): return the full block in data. No memory update.
  - e_cce_mem_wb: write data to the block. Response data='0.
  - e_cce_mem_uc_rd: bytes [addr offset, offset+2^size) of the block, right-justified into data[0], zero-extended.
  - e_cce_mem_uc_wr: low 2^size bytes of cmd data merged into the block at the addr byte offset (read-modify-write). Response data='0.
- Response header: msg_type, addr, size and payload (lce_id, way_id) are copied unchanged from the command.
- FSM states and transitions:
  - e_ready: mem_cmd_ready_o=1. On v&ready, latch the command into cmd_r, issue the SRAM read of the index, then go to e_access.
  - e_access: capture SRAM read data into blk_r; load the latency counter with latency_p; go to e_delay. If latency_p==0, go directly to e_write.
  - e_delay: decrement the counter each cycle. At 0, go to e_write.
  - e_write: for wb/uc_wr, issue the SRAM write of the merged block (wb writes the full cmd data). For other ops, no access. Form the response; go to e_resp.
  - e_resp: mem_resp_v_o=1, outputs held stable. On yumi go to e_ready.
- Latency: a command accepted in cycle 0 gives mem_resp_v_o at cycle 3+latency_p.
- Minimum initiation interval is 4+latency_p cycles, since the next command is accepted in the cycle after yumi. mem_cmd_ready_o is low in all states except e_ready.
- uc size beyond the block boundary (offset+2^size > block bytes) is an error; the assertion fires. Out-of-block bytes are ignored.
- Unsupported msg_type: answered like uc_rd with data='0. The assertion reports it.
- Read-after-write: a write in e_write is visible to any later command, because the SRAM is written before the next acceptance.

Decomposition:
- Size-to-byte-mask function and the block_off/index widths go in bp_me_pkg. The mem msg structs come from the existing bp_me_if macros.
- Storage: one bsg_mem_1rw_sync (width cce_block_width_p, els mem_els_p) instance.
- Byte merge/extract is a natural sub-module: bp_me_block_byte_merge (combinational shift+mask, shared with other ME blocks).

Test Plan:
- wb addr 0x8000_0040 with data pattern A, then rd 0x8000_0040 → resp rd with data==A, addr/way_id/lce_id echoed, v at cycle 3+latency_p after rd acceptance.
- wb block 0x...80 all 0x00, then uc_wr size_4 addr 0x...84 data 0xDEADBEEF, then uc_rd size_8 addr 0x...80 → data 0xDEADBEEF_00000000.
- uc_rd size_1 addr 0x...87 after the above → data 0x00000000_000000DE.
- mem_resp_yumi_i held low 20 cycles → mem_resp_v_o and resp stay stable, mem_cmd_ready_o=0 throughout. Yumi then gives ready=1 the next cycle.
- latency_p=0 and latency_p=7 builds: back-to-back rd/wb stream → response order equals command order, with the exact cycle counts above.
- reset_i asserted during e_delay of a wb → no response appears. A later rd of that block shows the previous contents, and ready=1 the cycle after reset deasserts.
